// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control unit: stall bus, stall patterns, FSM states.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W = 6;
  localparam int unsigned WORD_W  = 32;

  localparam logic              RST_ENABLE = 1'b1;
  localparam logic [WORD_W-1:0] ZERO_WORD  = '0;

  // Bit order {wb, mem, ex, id, if, pc}
  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;
  localparam stall_bus_t STALL_EXCP = 6'b011111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipe_ctrl_sat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Count up on inc, stop at all-ones; clr wins over inc
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall merge, exception flush sequencing, stall counter and watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              excp_req,
  input  logic [WORD_W-1:0] excp_handler,
  output stall_bus_t        stall,
  output logic              flush,
  output logic [WORD_W-1:0] new_pc,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              stall_timeout
);

  localparam int unsigned RUN_W = $clog2(STALL_TIMEOUT + 1);

  state_t            r_state;
  logic              r_flush;
  logic [WORD_W-1:0] r_new_pc;
  logic              r_timeout;
  stall_bus_t        w_req;
  stall_bus_t        w_stall;
  logic [RUN_W-1:0]  w_run_cnt;

  // Priority merge of the stage stall requests (mem > ex > id)
  always_comb begin
    w_req = STALL_NONE;
    if (stallreq_mem) begin
      w_req = STALL_MEM;
    end else if (stallreq_ex) begin
      w_req = STALL_EX;
    end else if (stallreq_id) begin
      w_req = STALL_ID;
    end
  end

  // Stall vector: zero-latency, overridden by the exception sequence
  always_comb begin
    w_stall = STALL_NONE;
    if (rst != RST_ENABLE) begin
      case (r_state)
        ST_RUN:   w_stall = excp_req ? STALL_EXCP : w_req;
        ST_PEND:  w_stall = STALL_EXCP;
        ST_FLUSH: w_stall = STALL_NONE;
        default:  w_stall = STALL_NONE;
      endcase
    end
  end

  // Exception FSM: latch handler, wait for MEM idle, one-cycle flush
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state  <= ST_RUN;
      r_flush  <= 1'b0;
      r_new_pc <= ZERO_WORD;
    end else begin
      r_flush <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (excp_req) begin
            r_new_pc <= excp_handler;
            if (stallreq_mem) begin
              r_state <= ST_PEND;
            end else begin
              r_state <= ST_FLUSH;
              r_flush <= 1'b1;
            end
          end
        end
        ST_PEND: begin
          if (!stallreq_mem) begin
            r_state <= ST_FLUSH;
            r_flush <= 1'b1;
          end
        end
        ST_FLUSH: r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  // Total stalled-cycle performance counter
  pipe_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_stall[0]),
    .clr (1'b0),
    .q   (stall_cnt)
  );

  // Consecutive stalled-cycle run length for the watchdog
  pipe_ctrl_sat_counter #(.W(RUN_W)) u_run_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_stall[0]),
    .clr (~w_stall[0]),
    .q   (w_run_cnt)
  );

  // Sticky watchdog: trips on the stalled cycle that completes the run
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_timeout <= 1'b0;
    end else if (w_stall[0] && (w_run_cnt >= RUN_W'(STALL_TIMEOUT - 1))) begin
      r_timeout <= 1'b1;
    end
  end

  assign stall         = w_stall;
  assign flush         = r_flush;
  assign new_pc        = r_new_pc;
  assign stall_timeout = r_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: behavioural model checked every cycle, directed literals, random traffic.
module tb_pipe_ctrl;

  localparam int unsigned TMO  = 8;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_id = 1'b0, s_ex = 1'b0, s_mem = 1'b0, excp = 1'b0;
  logic [31:0] hnd = '0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [CW-1:0] stall_cnt;
  logic        stall_timeout;

  int total = 0;
  int bad   = 0;

  // Model state: meaning-level, not the RTL encoding
  bit          m_pend;     // exception accepted, waiting for MEM
  bit          m_flush;    // this cycle is the flush cycle
  logic [31:0] m_handler;
  int          m_cnt;
  int          m_run;
  bit          m_to;

  pipe_ctrl #(.STALL_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id   (s_id),
    .stallreq_ex   (s_ex),
    .stallreq_mem  (s_mem),
    .excp_req      (excp),
    .excp_handler  (hnd),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_cnt     (stall_cnt),
    .stall_timeout (stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] model_stall();
    if (rst) return 6'b000000;
    if (m_flush) return 6'b000000;
    if (m_pend) return 6'b011111;
    if (excp) return 6'b011111;
    if (s_mem) return 6'b011111;
    if (s_ex) return 6'b001111;
    if (s_id) return 6'b000111;
    return 6'b000000;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_flush = 0; m_handler = '0;
    m_cnt = 0; m_run = 0; m_to = 0;
  endtask

  // Advance the model across the coming clock edge using current inputs
  task automatic model_update();
    logic [5:0] s;
    bit n_pend, n_flush;
    s = model_stall();
    if (rst) begin
      model_reset();
      return;
    end
    if (s[0]) begin
      if (m_cnt < CMAX) m_cnt++;
      if (m_run < 1000) m_run++;
    end else begin
      m_run = 0;
    end
    if (m_run >= int'(TMO)) m_to = 1;
    n_pend = 0; n_flush = 0;
    if (m_flush) begin
      n_flush = 0;
    end else if (m_pend) begin
      if (s_mem) n_pend = 1; else n_flush = 1;
    end else if (excp) begin
      m_handler = hnd;
      if (s_mem) n_pend = 1; else n_flush = 1;
    end
    m_pend = n_pend;
    m_flush = n_flush;
  endtask

  task automatic compare_all();
    chk("stall", 32'(stall), 32'(model_stall()));
    chk("flush", 32'(flush), 32'(m_flush));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
    if (m_flush) chk("new_pc", new_pc, m_handler);
  endtask

  // One cycle: drive after negedge, compare, then let the model take the edge
  task automatic step(input bit r, input bit id, input bit ex, input bit mem,
                      input bit e, input logic [31:0] h);
    @(negedge clk);
    rst = r; s_id = id; s_ex = ex; s_mem = mem; excp = e; hnd = h;
    #1;
    compare_all();
    model_update();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);

    // Reset values
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_tmo", 32'(stall_timeout), 32'h0);

    // ID-only stall, counter, priority merge
    step(0, 1, 0, 0, 0, 0);
    chk("id_stall", 32'(stall), 32'h07);
    step(0, 0, 0, 0, 0, 0);
    chk("id_cnt", 32'(stall_cnt), 32'h1);
    step(0, 1, 0, 1, 0, 0);
    chk("id_mem_stall", 32'(stall), 32'h1F);
    step(0, 1, 1, 0, 0, 0);
    chk("id_ex_stall", 32'(stall), 32'h0F);

    // Exception with MEM idle
    step(0, 1, 0, 0, 1, 32'h20);
    chk("excp_n_stall", 32'(stall), 32'h1F);
    step(0, 1, 0, 0, 0, 0);
    chk("excp_n1_flush", 32'(flush), 32'h1);
    chk("excp_n1_pc", new_pc, 32'h20);
    chk("excp_n1_stall", 32'(stall), 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("excp_n2_flush", 32'(flush), 32'h0);

    // Exception while MEM waits 3 cycles; second exception ignored
    step(0, 0, 0, 1, 1, 32'h100);
    chk("pend_n_stall", 32'(stall), 32'h1F);
    step(0, 0, 0, 1, 1, 32'h200);
    chk("pend_n1_stall", 32'(stall), 32'h1F);
    step(0, 0, 0, 1, 0, 0);
    chk("pend_n2_flush", 32'(flush), 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("pend_n3_stall", 32'(stall), 32'h1F);
    chk("pend_n3_flush", 32'(flush), 32'h0);
    step(0, 1, 0, 1, 0, 0);
    chk("pend_n4_flush", 32'(flush), 32'h1);
    chk("pend_n4_pc", new_pc, 32'h100);
    chk("pend_n4_stall", 32'(stall), 32'h0);

    // Reset during PEND discards the exception
    step(0, 0, 0, 1, 1, 32'h300);
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rstp_flush", 32'(flush), 32'h0);
    chk("rstp_pc", new_pc, 32'h0);
    chk("rstp_cnt", 32'(stall_cnt), 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("rstp_flush2", 32'(flush), 32'h0);

    // Watchdog: 8-cycle stall trips and stays
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("wd8_tmo", 32'(stall_timeout), 32'h1);
    chk("wd8_cnt", 32'(stall_cnt), 32'h8);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    chk("wd8_sticky", 32'(stall_timeout), 32'h1);

    // 7 + gap + 7 does not trip; then counter saturates
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("wd7_tmo", 32'(stall_timeout), 32'h0);
    chk("wd7_cnt", 32'(stall_cnt), 32'hE);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("sat_cnt", 32'(stall_cnt), 32'hF);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 97) == 0,
           ($urandom % 3) == 0,
           ($urandom % 5) == 0,
           ($urandom % 3) == 0,
           ($urandom % 8) == 0,
           $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
